game_timer_ctrl: RTL and testbench

Controls the Sudoku game session. It runs the IDLE/RUNNING/PAUSED/FINISHED state machine and divides clk_50MHz down to a 1 s tick. It counts elapsed seconds and computes the score with a multi-cycle iterative divider. Its outputs are the live timer and score for the display, plus a final-score handshake to the results/ranking logic.

---
 rtl/game_pkg.sv | 25 ++
 rtl/game_timer_ctrl_score_div.sv | 75 +++++++
 rtl/game_timer_ctrl.sv | 151 +++++++++++++++
 tb/tb_game_timer_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the Sudoku game session controller.
//   game_state_t : session state, encoded as driven on the state output
//   SCORE_W/TIMER_W : display widths of score and elapsed-seconds timer
//   NUM_W/DEN_W  : operand widths of the score divider
//   DEF_*        : default grace period, time limit and full score
package game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        PAUSED   = 2'd2,
        FINISHED = 2'd3
    } game_state_t;

    localparam int SCORE_W = 8;
    localparam int TIMER_W = 12;
    localparam int NUM_W   = 18;
    localparam int DEN_W   = TIMER_W;
    localparam int CNT_W   = 5;

    localparam int DEF_GRACE_S   = 60;
    localparam int DEF_LIMIT_S   = 1800;
    localparam int DEF_MAX_SCORE = 100;

endpackage

// File: rtl/game_timer_ctrl_score_div.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
//   clk_50MHz, rst_n : clock, asynchronous active-low reset
//   start            : load num/den and begin (ignored while abort is high)
//   abort            : drop any division in flight
//   num, den         : dividend (NUM_W bits) and divisor (DEN_W bits)
//   busy             : a division is in flight
//   done             : high in the last iteration cycle; quo is valid then
//   quo              : quotient, valid while done is high
// The result is taken on the edge that ends the done cycle, 18 cycles after
// the start edge. A new start may be accepted in the done cycle.
module score_div
    import game_pkg::*;
(
    input  logic             clk_50MHz,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quo
);

    logic [NUM_W-1:0] q_reg;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den_reg;
    logic [CNT_W-1:0] cnt;

    logic [DEN_W:0]   trial;
    logic [DEN_W:0]   diff;
    logic             fits;
    logic [DEN_W-1:0] rem_next;
    logic [NUM_W-1:0] q_next;

    // The partial remainder is always below den, so trial < 2*den and the
    // sign bit of trial-den is a reliable "does not fit" flag.
    always_comb begin
        trial    = {rem, q_reg[NUM_W-1]};
        diff     = trial - {1'b0, den_reg};
        fits     = ~diff[DEN_W];
        rem_next = fits ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
        q_next   = {q_reg[NUM_W-2:0], fits};
    end

    assign done = busy && (cnt == CNT_W'(1));
    assign quo  = q_next;

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= '0;
            rem     <= '0;
            den_reg <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (abort) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            q_reg   <= num;
            rem     <= '0;
            den_reg <= den;
            cnt     <= CNT_W'(NUM_W);
            busy    <= 1'b1;
        end else if (busy) begin
            q_reg <= q_next;
            rem   <= rem_next;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// Sudoku game session controller: session FSM, 1 s prescaler, elapsed-seconds
// timer and score computation with a final-score handshake.
//   clk_50MHz, rst_n     : clock, asynchronous active-low reset
//   start, pause, finish : one-cycle command pulses
//   timer                : elapsed seconds (saturates at LIMIT_S)
//   score, score_valid   : current score; valid low while a division runs
//   state                : 0 IDLE, 1 RUNNING, 2 PAUSED, 3 FINISHED
//   done                 : one-cycle pulse, final score valid in FINISHED
module game_timer_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int GRACE_S   = DEF_GRACE_S,
    parameter int LIMIT_S   = DEF_LIMIT_S,
    parameter int MAX_SCORE = DEF_MAX_SCORE
) (
    input  logic               clk_50MHz,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               finish,
    output logic [TIMER_W-1:0] timer,
    output logic [SCORE_W-1:0] score,
    output logic               score_valid,
    output logic [1:0]         state,
    output logic               done
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    game_state_t      st;
    logic [PRE_W-1:0] presc;
    logic             div_req;    // timer moved into the divided range, not yet launched
    logic             done_wait;  // in FINISHED, final score not yet announced

    logic             tick_now;
    logic             timeout;
    logic             new_game;
    logic             div_start;
    logic             div_abort;
    logic             div_busy;
    logic             div_done;
    logic [NUM_W-1:0] div_quo;
    logic [NUM_W-1:0] t_excess;
    logic [NUM_W-1:0] div_num;
    logic [SCORE_W-1:0] score_calc;

    assign state = st;

    // finish and pause take the cycle; a coinciding tick is lost.
    assign tick_now  = (st == RUNNING) && (presc == PRE_LAST) && !pause && !finish;
    assign timeout   = tick_now && (timer == TIMER_W'(LIMIT_S - 1));
    assign new_game  = start && ((st == IDLE) || (st == FINISHED));
    assign div_abort = new_game || timeout;
    // A queued request relaunches in the same cycle the previous result lands.
    assign div_start = div_req && (!div_busy || div_done) && !div_abort;

    assign t_excess = NUM_W'(timer) - NUM_W'(GRACE_S);
    assign div_num  = t_excess * NUM_W'(MAX_SCORE);
    assign score_calc = (div_quo >= NUM_W'(MAX_SCORE)) ? '0
                      : SCORE_W'(MAX_SCORE) - div_quo[SCORE_W-1:0];

    score_div u_div (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (div_abort),
        .num       (div_num),
        .den       (DEN_W'(LIMIT_S - GRACE_S)),
        .busy      (div_busy),
        .done      (div_done),
        .quo       (div_quo)
    );

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            presc       <= '0;
            timer       <= '0;
            score       <= SCORE_W'(MAX_SCORE);
            score_valid <= 1'b1;
            done        <= 1'b0;
            div_req     <= 1'b0;
            done_wait   <= 1'b0;
        end else begin
            done <= 1'b0;

            // Divider bookkeeping; FSM assignments below take precedence.
            if (div_done) begin
                score <= score_calc;
            end
            if (div_start) begin
                div_req     <= 1'b0;
                score_valid <= 1'b0;
            end else if (div_done) begin
                score_valid <= 1'b1;
            end

            case (st)
                IDLE, FINISHED: begin
                    if (start) begin
                        st          <= RUNNING;
                        presc       <= '0;
                        timer       <= '0;
                        score       <= SCORE_W'(MAX_SCORE);
                        score_valid <= 1'b1;
                        div_req     <= 1'b0;
                        done_wait   <= 1'b0;
                    end else if (st == FINISHED && done_wait && score_valid
                                 && !div_busy && !div_req) begin
                        done      <= 1'b1;
                        done_wait <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (finish) begin
                        st        <= FINISHED;
                        done_wait <= 1'b1;
                    end else if (pause) begin
                        st <= PAUSED;
                    end else if (presc == PRE_LAST) begin
                        presc <= '0;
                        timer <= timer + TIMER_W'(1);
                        if (timeout) begin
                            st          <= FINISHED;
                            score       <= '0;
                            score_valid <= 1'b1;
                            div_req     <= 1'b0;
                            done_wait   <= 1'b1;
                        end else if (timer >= TIMER_W'(GRACE_S)) begin
                            div_req <= 1'b1;
                        end
                    end else begin
                        presc <= presc + PRE_W'(1);
                    end
                end
                PAUSED: begin
                    if (finish) begin
                        st        <= FINISHED;
                        done_wait <= 1'b1;
                    end else if (pause) begin
                        st <= RUNNING;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl with a 4-cycle second: a vector table for the
// command/state basics, hand-written sequences for division latency, pause
// timing, timeout, finish/abort handshakes and async reset, then a random
// command phase checked against a rule-level session model.
module tb_game_timer_ctrl;

    localparam int TB_CLK_HZ = 4;
    localparam int GRACE     = 60;
    localparam int LIMIT     = 1800;
    localparam int MAXS      = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic        finish;
    logic [11:0] timer;
    logic [7:0]  score;
    logic        score_valid;
    logic [1:0]  state;
    logic        done;

    always #5 clk = ~clk;

    game_timer_ctrl #(
        .CLK_HZ    (TB_CLK_HZ),
        .GRACE_S   (GRACE),
        .LIMIT_S   (LIMIT),
        .MAX_SCORE (MAXS)
    ) dut (
        .clk_50MHz   (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .finish      (finish),
        .timer       (timer),
        .score       (score),
        .score_valid (score_valid),
        .state       (state),
        .done        (done)
    );

    typedef struct {
        bit s;
        bit p;
        bit f;
        int cyc;
        int st;
        int tm;
        int sc;
        int vl;
        int dn;
    } vec_t;

    vec_t tbl[20];

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    // Reference session model
    bit model_on = 1'b0;
    int m_state;
    int m_timer;
    int m_cnt;
    int m_stable;
    int m_fin_cycles;
    bit m_done_seen;

    function automatic vec_t mkv(bit s, bit p, bit f, int cyc,
                                 int st, int tm, int sc, int vl, int dn);
        vec_t v;
        v.s = s; v.p = p; v.f = f; v.cyc = cyc;
        v.st = st; v.tm = tm; v.sc = sc; v.vl = vl; v.dn = dn;
        return v;
    endfunction

    function automatic int ref_score(int t);
        if (t <= GRACE) return MAXS;
        if (t >= LIMIT) return 0;
        return MAXS - ((t - GRACE) * MAXS) / (LIMIT - GRACE);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_enter_fin();
        m_state      = 3;
        m_done_seen  = 1'b0;
        m_fin_cycles = 0;
    endtask

    // Applies the session rules to the inputs of the coming edge.
    task automatic model_update();
        int old_t;
        old_t = m_timer;
        case (m_state)
            0, 3: begin
                if (start) begin
                    m_state = 1; m_timer = 0; m_cnt = 0;
                end
            end
            1: begin
                if (finish) model_enter_fin();
                else if (pause) m_state = 2;
                else if (m_cnt == TB_CLK_HZ - 1) begin
                    m_cnt = 0;
                    m_timer++;
                    if (m_timer == LIMIT) model_enter_fin();
                end else m_cnt++;
            end
            default: begin
                if (finish) model_enter_fin();
                else if (pause) m_state = 1;
            end
        endcase
        if (m_timer != old_t) m_stable = 0;
        else m_stable++;
    endtask

    task automatic model_check();
        check("rnd_state", state, m_state);
        check("rnd_timer", timer, m_timer);
        if (score_valid && m_stable >= 1)
            check("rnd_score", score, ref_score(m_timer));
        if (done) begin
            check("rnd_done_state", state, 3);
            check("rnd_done_valid", score_valid, 1);
            check("rnd_done_score", score, ref_score(m_timer));
            check("rnd_done_once", m_done_seen, 0);
            m_done_seen = 1'b1;
        end
        if (m_state == 3) begin
            m_fin_cycles++;
            if (m_fin_cycles == 100) check("rnd_done_seen", m_done_seen, 1);
        end
    endtask

    task automatic step();
        if (model_on) model_update();
        @(posedge clk);
        @(negedge clk);
        if (done) done_cnt++;
        if (model_on) model_check();
    endtask

    task automatic pulse(input bit s, input bit p, input bit f);
        start = s; pause = p; finish = f;
        step();
        start = 1'b0; pause = 1'b0; finish = 1'b0;
    endtask

    task automatic wait_timer(input int target, input int budget);
        int n;
        n = 0;
        while (int'(timer) != target && n < budget) begin
            step();
            n++;
        end
        check($sformatf("reach_timer_%0d", target), timer, target);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!score_valid && n < budget) begin
            step();
            n++;
        end
        check("valid_return", score_valid, 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int j;
        int errs;
        int errs2;
        int d0;

        tbl[0]  = mkv(0, 0, 0, 1,  0, 0, 100, 1, 0);
        tbl[1]  = mkv(0, 1, 0, 1,  0, 0, 100, 1, 0);
        tbl[2]  = mkv(0, 0, 1, 1,  0, 0, 100, 1, 0);
        tbl[3]  = mkv(1, 0, 0, 1,  1, 0, 100, 1, 0);
        tbl[4]  = mkv(0, 0, 0, 4,  1, 1, 100, 1, 0);
        tbl[5]  = mkv(1, 0, 0, 1,  1, 1, 100, 1, 0);
        tbl[6]  = mkv(0, 0, 0, 2,  1, 1, 100, 1, 0);
        tbl[7]  = mkv(0, 1, 0, 1,  2, 1, 100, 1, 0);
        tbl[8]  = mkv(0, 0, 0, 10, 2, 1, 100, 1, 0);
        tbl[9]  = mkv(1, 0, 0, 1,  2, 1, 100, 1, 0);
        tbl[10] = mkv(0, 1, 0, 1,  1, 1, 100, 1, 0);
        tbl[11] = mkv(0, 0, 0, 1,  1, 2, 100, 1, 0);
        tbl[12] = mkv(0, 0, 0, 8,  1, 4, 100, 1, 0);
        tbl[13] = mkv(0, 0, 1, 1,  3, 4, 100, 1, 0);
        tbl[14] = mkv(0, 0, 0, 1,  3, 4, 100, 1, 1);
        tbl[15] = mkv(0, 0, 0, 1,  3, 4, 100, 1, 0);
        tbl[16] = mkv(0, 1, 0, 1,  3, 4, 100, 1, 0);
        tbl[17] = mkv(1, 0, 0, 1,  1, 0, 100, 1, 0);
        tbl[18] = mkv(0, 0, 0, 3,  1, 0, 100, 1, 0);
        tbl[19] = mkv(0, 0, 0, 1,  1, 1, 100, 1, 0);

        // Clock/reset
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; finish = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_score", score, MAXS);
        check("rst_valid", score_valid, 1);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 20; i++) begin
            start = tbl[i].s; pause = tbl[i].p; finish = tbl[i].f;
            step();
            start = 1'b0; pause = 1'b0; finish = 1'b0;
            for (int k = 1; k < tbl[i].cyc; k++) step();
            check($sformatf("vec%0d_state", i), state, tbl[i].st);
            check($sformatf("vec%0d_timer", i), timer, tbl[i].tm);
            check($sformatf("vec%0d_score", i), score, tbl[i].sc);
            check($sformatf("vec%0d_valid", i), score_valid, tbl[i].vl);
            check($sformatf("vec%0d_done", i), done, tbl[i].dn);
        end

        // Grace period: full score, never invalid
        errs = 0; errs2 = 0; n = 0;
        while (int'(timer) < GRACE && n < 400) begin
            step();
            n++;
            if (!score_valid) errs++;
            if (int'(score) != MAXS) errs2++;
        end
        check("grace_reached", timer, GRACE);
        check("grace_valid_drops", errs, 0);
        check("grace_score_errs", errs2, 0);

        // First division from an idle divider: 18 invalid cycles
        wait_timer(77, 200);
        pulse(0, 1, 0);
        wait_valid(100);
        check("score_t77", score, 100);
        pulse(0, 1, 0);
        wait_timer(78, 20);
        pulse(0, 1, 0);
        n = 0;
        while (!score_valid && n < 40) begin
            step();
            n++;
        end
        check("div_latency", n, 18);
        check("score_t78", score, 99);
        check("paused_t78", state, 2);

        // Pause at 100: timer frozen, prescaler count held across the pause
        pulse(0, 1, 0);
        wait_timer(100, 200);
        j = $urandom_range(0, 3);
        repeat (j) step();
        pulse(0, 1, 0);
        errs = 0;
        repeat (40) begin
            step();
            if (int'(timer) != 100) errs++;
        end
        check("paused_frozen", errs, 0);
        pulse(0, 1, 0);
        n = 0;
        while (int'(timer) == 100 && n < 10) begin
            step();
            n++;
        end
        check("resume_latency", n, 4 - j);

        // Mid-range and last-second scores
        wait_timer(930, 4000);
        pulse(0, 1, 0);
        wait_valid(100);
        check("score_t930", score, 50);
        pulse(0, 1, 0);
        wait_timer(1799, 4000);
        pulse(0, 1, 0);
        wait_valid(100);
        check("score_t1799", score, 1);
        pulse(0, 1, 0);

        // Timeout
        done_cnt = 0;
        wait_timer(1800, 20);
        check("to_state", state, 3);
        check("to_score", score, 0);
        check("to_valid", score_valid, 1);
        check("to_done_early", done, 0);
        step();
        check("to_done", done, 1);
        repeat (20) step();
        check("to_timer_hold", timer, 1800);
        check("to_state_hold", state, 3);
        check("to_done_count", done_cnt, 1);

        // New game, finish while the divider is busy
        pulse(1, 0, 0);
        check("ng_state", state, 1);
        check("ng_timer", timer, 0);
        check("ng_score", score, MAXS);
        check("ng_valid", score_valid, 1);
        wait_timer(930, 4000);
        repeat (3) step();
        pulse(0, 0, 1);
        check("fb_state", state, 3);
        check("fb_timer", timer, 930);
        check("fb_valid_low", score_valid, 0);
        wait_valid(100);
        check("fb_done_early", done, 0);
        step();
        check("fb_done", done, 1);
        check("fb_score", score, 50);
        pulse(1, 0, 0);
        d0 = done_cnt;
        check("fb_restart_state", state, 1);
        check("fb_restart_timer", timer, 0);
        check("fb_restart_score", score, MAXS);
        repeat (30) step();
        check("fb_no_done", done_cnt, d0);

        // finish coinciding with a tick at 200
        wait_timer(200, 1000);
        repeat (3) step();
        pulse(0, 0, 1);
        check("ft_timer", timer, 200);
        check("ft_state", state, 3);
        n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        check("ft_done", done, 1);
        check("ft_score", score, 92);
        check("ft_timer_done", timer, 200);

        // start while waiting for the final score aborts it
        pulse(1, 0, 0);
        wait_timer(61, 400);
        repeat (2) step();
        pulse(0, 0, 1);
        check("ab_state_fin", state, 3);
        check("ab_valid_low", score_valid, 0);
        pulse(1, 0, 0);
        d0 = done_cnt;
        check("ab_state", state, 1);
        check("ab_score", score, MAXS);
        check("ab_valid", score_valid, 1);
        repeat (40) step();
        check("ab_no_done", done_cnt, d0);
        check("ab_valid_after", score_valid, 1);

        // Asynchronous reset during a division
        wait_timer(61, 400);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("ar_state", state, 0);
        check("ar_timer", timer, 0);
        check("ar_score", score, MAXS);
        check("ar_valid", score_valid, 1);
        check("ar_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random commands against the session model
        m_state = 0; m_timer = 0; m_cnt = 0; m_stable = 100;
        m_fin_cycles = 0; m_done_seen = 1'b1;
        model_on = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            start  = ($urandom_range(0, 99) == 0);
            pause  = ($urandom_range(0, 59) == 0);
            finish = ($urandom_range(0, 299) == 0);
            step();
        end
        start = 1'b0; pause = 1'b0; finish = 1'b0;
        model_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
